// File: rtl/daq_link_pkg.sv
`default_nettype none
// daq_link_pkg: shared types, K-character constants and word/K replication helper.
// Rev 1.0
package daq_link_pkg;

  typedef enum logic [0:0] {
    SEND = 1'b0,
    CC   = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_DATA = 2'd1,
    SEL_CC   = 2'd2
  } sel_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K23_7 = 8'hF7;

  // Widest supported fabric word; callers take the low DW / NK bits.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  k;
  } wk_t;

  function automatic wk_t replicate(input logic [15:0] word, input logic [1:0] kflags,
                                    input int reps);
    wk_t r;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      if (i < reps) begin
        r.data[i*16 +: 16] = word;
        r.k[i*2 +: 2]      = kflags;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/daq_link_framer_if.sv
`default_nettype none
// daq_link_framer_if: event-builder input stream plus GTX-facing outputs and status.
// Rev 1.0
interface daq_link_framer_if #(
  parameter int DW = 16
);
  localparam int NK = DW / 8;

  logic [DW-1:0] TXD;
  logic          TXD_VLD;
  logic          TXD_EOF;
  logic          TXD_RDY;
  logic [DW-1:0] TX_DATA;
  logic [NK-1:0] TX_K;
  logic          OVERFLOW;
  logic          UNDERRUN;

  modport master (
    output TXD, TXD_VLD, TXD_EOF,
    input  TXD_RDY, TX_DATA, TX_K, OVERFLOW, UNDERRUN
  );

  modport slave (
    input  TXD, TXD_VLD, TXD_EOF,
    output TXD_RDY, TX_DATA, TX_K, OVERFLOW, UNDERRUN
  );

endinterface
`default_nettype wire

// File: rtl/daq_link_fifo.sv
`default_nettype none
// daq_link_fifo: synchronous FIFO, registered read data (no first-word fall-through).
// Rev 1.0
module daq_link_fifo #(
  parameter int WIDTH = 17,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             full_nxt
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign count_nxt = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  // Lookahead lets the owner register a ready flag that is exact in the same cycle.
  assign full_nxt  = (count_nxt == DEPTH_C);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      rdata  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        rdata  <= mem[rd_ptr];
      end
      count <= count_nxt;
      full  <= full_nxt;
      empty <= (count_nxt == '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/daq_link_framer.sv
`default_nettype none
// daq_link_framer: 8b10b TX framer (FIFO, idle fill, frame-safe clock correction).
// Rev 1.0; DAQ_LINK_FRAMER_STATS_EN adds FRAME_CNT / CC_CNT.
module daq_link_framer
  import daq_link_pkg::*;
#(
  parameter int          DW        = 16,
  parameter int          FIFO_AW   = 4,
  parameter int          CC_PERIOD = 5000,
  parameter int          CC_LEN    = 2,
  parameter logic [15:0] IDLE_WORD = {8'h50, K28_5},
  parameter logic [1:0]  IDLE_K    = 2'b01,
  parameter logic [15:0] CC_WORD   = {K23_7, K23_7},
  parameter logic [1:0]  CC_K      = 2'b11
) (
  input  logic               CLK,
  input  logic               RST,
`ifdef DAQ_LINK_FRAMER_STATS_EN
  output logic [31:0]        FRAME_CNT,
  output logic [15:0]        CC_CNT,
`endif
  daq_link_framer_if.slave   link
);

  localparam int NK = DW / 8;
  localparam int TW = (CC_PERIOD > 2) ? $clog2(CC_PERIOD) : 1;
  localparam int CW = (CC_LEN > 2) ? $clog2(CC_LEN) : 1;

  localparam wk_t            IDLE_WK   = replicate(IDLE_WORD, IDLE_K, DW / 16);
  localparam wk_t            CC_WK     = replicate(CC_WORD, CC_K, DW / 16);
  localparam logic [DW-1:0]  IDLE_D    = IDLE_WK.data[DW-1:0];
  localparam logic [NK-1:0]  IDLE_KR   = IDLE_WK.k[NK-1:0];
  localparam logic [DW-1:0]  CC_D      = CC_WK.data[DW-1:0];
  localparam logic [NK-1:0]  CC_KR     = CC_WK.k[NK-1:0];
  localparam logic [TW-1:0]  TIMER_MAX = TW'(CC_PERIOD - 1);
  localparam logic [CW-1:0]  CC_LOAD   = CW'((CC_LEN > 1) ? CC_LEN - 2 : 0);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cc_cnt;
  logic [CW-1:0] cc_cnt_nxt;
  logic [TW-1:0] timer;
  logic          wrap;
  logic          cc_pending;
  logic          in_frame;
  logic          frame_eff;
  logic          go_cc;
  logic          last_cc;
  logic          pop;
  logic          set_underrun;
  sel_t          sel;
  sel_t          sel_nxt;
  logic          rdy;
  logic          overflow;
  logic          underrun;
  logic [DW-1:0] tx_data;
  logic [NK-1:0] tx_k;

  logic [DW:0]   fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_full_nxt;

  daq_link_fifo #(
    .WIDTH (DW + 1),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (link.TXD_VLD && rdy && !fifo_full),
    .wdata    ({link.TXD_EOF, link.TXD}),
    .pop      (pop),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .full_nxt (fifo_full_nxt)
  );

  // A word popped last cycle sits in the FIFO read register and is already committed
  // to the output, so its EOF bit decides frame membership for this cycle's choice.
  assign frame_eff = (sel == SEL_DATA) ? !fifo_rdata[DW] : in_frame;
  assign wrap      = (timer == TIMER_MAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= SEND;
      cc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      cc_cnt <= cc_cnt_nxt;
    end
  end

  // The SEND cycle that starts a correction already emits its first CC word.
  always_comb begin
    state_nxt  = state;
    cc_cnt_nxt = cc_cnt;
    go_cc      = 1'b0;
    last_cc    = 1'b0;
    case (state)
      SEND: begin
        if (cc_pending && !frame_eff) begin
          go_cc      = 1'b1;
          cc_cnt_nxt = CC_LOAD;
          if (CC_LEN > 1) begin
            state_nxt = CC;
          end else begin
            last_cc = 1'b1;
          end
        end
      end
      CC: begin
        if (cc_cnt == '0) begin
          state_nxt = SEND;
          last_cc   = 1'b1;
        end else begin
          cc_cnt_nxt = cc_cnt - 1'b1;
        end
      end
      default: state_nxt = SEND;
    endcase
  end

  always_comb begin
    sel_nxt      = SEL_IDLE;
    pop          = 1'b0;
    set_underrun = 1'b0;
    case (state)
      SEND: begin
        if (go_cc) begin
          sel_nxt = SEL_CC;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          sel_nxt = SEL_DATA;
        end else begin
          set_underrun = frame_eff;
        end
      end
      CC:      sel_nxt = SEL_CC;
      default: sel_nxt = SEL_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      timer      <= '0;
      cc_pending <= 1'b0;
      in_frame   <= 1'b0;
      sel        <= SEL_IDLE;
      rdy        <= 1'b0;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
      tx_data    <= IDLE_D;
      tx_k       <= IDLE_KR;
    end else begin
      timer      <= wrap ? '0 : timer + 1'b1;
      cc_pending <= wrap | (cc_pending & ~go_cc);
      in_frame   <= frame_eff;
      sel        <= sel_nxt;
      rdy        <= ~fifo_full_nxt;
      if (link.TXD_VLD && !rdy) begin
        overflow <= 1'b1;
      end
      if (set_underrun) begin
        underrun <= 1'b1;
      end
      case (sel)
        SEL_DATA: begin
          tx_data <= fifo_rdata[DW-1:0];
          tx_k    <= '0;
        end
        SEL_CC: begin
          tx_data <= CC_D;
          tx_k    <= CC_KR;
        end
        default: begin
          tx_data <= IDLE_D;
          tx_k    <= IDLE_KR;
        end
      endcase
    end
  end

  assign link.TXD_RDY  = rdy;
  assign link.TX_DATA  = tx_data;
  assign link.TX_K     = tx_k;
  assign link.OVERFLOW = overflow;
  assign link.UNDERRUN = underrun;

`ifdef DAQ_LINK_FRAMER_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] cc_done;

  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt <= '0;
      cc_done   <= '0;
    end else begin
      if (sel == SEL_DATA && fifo_rdata[DW]) begin
        frame_cnt <= frame_cnt + 32'd1;
      end
      if (last_cc && cc_done != 16'hFFFF) begin
        cc_done <= cc_done + 16'd1;
      end
    end
  end

  assign FRAME_CNT = frame_cnt;
  assign CC_CNT    = cc_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_daq_link_framer.sv
`default_nettype none
// tb_daq_link_framer: directed + random stimulus against a queue-based reference model.
// Rev 1.0
module tb_daq_link_framer;

  localparam int DW        = 32;
  localparam int NK        = DW / 8;
  localparam int AW        = 4;
  localparam int DEPTH     = 16;
  localparam int CC_PERIOD = 48;
  localparam int CC_LEN    = 18;

  localparam logic [DW-1:0] IDLE_D = {2{16'h50BC}};
  localparam logic [NK-1:0] IDLE_K = {2{2'b01}};
  localparam logic [DW-1:0] CC_D   = {2{16'hF7F7}};
  localparam logic [NK-1:0] CC_K   = {2{2'b11}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  daq_link_framer_if #(.DW(DW)) link ();

`ifdef DAQ_LINK_FRAMER_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] cc_cnt;
`endif

  daq_link_framer #(
    .DW        (DW),
    .FIFO_AW   (AW),
    .CC_PERIOD (CC_PERIOD),
    .CC_LEN    (CC_LEN)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
`ifdef DAQ_LINK_FRAMER_STATS_EN
    .FRAME_CNT (frame_cnt),
    .CC_CNT    (cc_cnt),
`endif
    .link      (link)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: queue of {eof,data}, per-cycle rule evaluation.
  logic [DW:0]   q[$];
  int            m_timer;
  int            m_ccrem;
  int            m_kind;      // 0 idle, 1 data, 2 cc: chosen this cycle, on TX next edge
  int            m_frames;
  int            m_ccs;
  bit            m_pend;
  bit            m_inf;
  bit            m_rdy;
  bit            m_ovf;
  bit            m_und;
  logic [DW:0]   m_word;
  logic [DW-1:0] exp_d;
  logic [NK-1:0] exp_k;

  task automatic model_edge();
    bit wrap;
    bit go;
    if (rst) begin
      q.delete();
      m_timer = 0; m_ccrem = 0; m_kind = 0; m_frames = 0; m_ccs = 0;
      m_pend = 0; m_inf = 0; m_rdy = 0; m_ovf = 0; m_und = 0;
      m_word = '0; exp_d = IDLE_D; exp_k = IDLE_K;
    end else begin
      case (m_kind)
        1: begin
          exp_d = m_word[DW-1:0];
          exp_k = '0;
          if (m_word[DW]) m_frames++;
        end
        2: begin exp_d = CC_D; exp_k = CC_K; end
        default: begin exp_d = IDLE_D; exp_k = IDLE_K; end
      endcase
      go = 0;
      if (m_ccrem > 0) begin
        m_kind = 2;
        m_ccrem--;
        if (m_ccrem == 0 && m_ccs < 65535) m_ccs++;
      end else if (m_pend && !m_inf) begin
        m_kind = 2;
        go = 1;
        m_ccrem = CC_LEN - 1;
        if (m_ccrem == 0 && m_ccs < 65535) m_ccs++;
      end else if (q.size() > 0) begin
        m_word = q.pop_front();
        m_kind = 1;
        m_inf  = !m_word[DW];
      end else begin
        m_kind = 0;
        if (m_inf) m_und = 1;
      end
      if (link.TXD_VLD) begin
        if (m_rdy) q.push_back({link.TXD_EOF, link.TXD});
        else m_ovf = 1;
      end
      wrap    = (m_timer == CC_PERIOD - 1);
      m_timer = wrap ? 0 : m_timer + 1;
      m_pend  = wrap || (m_pend && !go);
      m_rdy   = (q.size() < DEPTH);
    end
  endtask

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    cmp("tx_data", link.TX_DATA, exp_d);
    cmp("tx_k", link.TX_K, exp_k);
    cmp("txd_rdy", link.TXD_RDY, m_rdy);
    cmp("overflow", link.OVERFLOW, m_ovf);
    cmp("underrun", link.UNDERRUN, m_und);
`ifdef DAQ_LINK_FRAMER_STATS_EN
    cmp("frame_cnt", frame_cnt, m_frames);
    cmp("cc_cnt", cc_cnt, m_ccs);
`endif
  endtask

  task automatic drive(input bit v, input bit e, input logic [DW-1:0] d);
    link.TXD_VLD = v;
    link.TXD_EOF = e;
    link.TXD     = d;
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic expect_cc_after(input logic [DW-1:0] eof_word, input int budget,
                                 input string tag);
    bit seen = 0;
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle();
      if (seen) begin
        cmp(tag, {link.TX_K, link.TX_DATA}, {CC_K, CC_D});
        done = 1;
      end else if (link.TX_DATA === eof_word && link.TX_K === '0) begin
        seen = 1;
      end
    end
    if (!done) timeout(tag);
  endtask

  initial begin
    int cnt;
    bit hit;
    drive(0, 0, '0);
    rst = 1'b1;
    repeat (3) cycle();
    cmp("rst_tx_data", link.TX_DATA, IDLE_D);
    cmp("rst_tx_k", link.TX_K, IDLE_K);
    cmp("rst_rdy", link.TXD_RDY, 1'b0);

    rst = 1'b0;
    cycle();
    cmp("rdy_after_release", link.TXD_RDY, 1'b1);
    repeat (5) cycle();
    cmp("idle_after_release", {link.TX_K, link.TX_DATA}, {IDLE_K, IDLE_D});

    // Three-word burst: first word on TX two edges after its write edge.
    for (int i = 1; i <= 3; i++) begin
      drive(1, i == 3, DW'(i));
      cycle();
    end
    drive(0, 0, '0);
    cmp("burst_w1", {link.TX_K, link.TX_DATA}, {4'h0, 32'd1});
    cycle();
    cmp("burst_w2", link.TX_DATA, 32'd2);
    cycle();
    cmp("burst_w3", link.TX_DATA, 32'd3);
    cycle();
    cmp("burst_then_idle", link.TX_DATA, IDLE_D);
    cmp("burst_no_underrun", link.UNDERRUN, 1'b0);

    // Ten-word frame straddling the timer wrap.
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_timer == CC_PERIOD - 5) hit = 1;
      else cycle();
    end
    if (!hit) timeout("straddle_align");
    for (int i = 0; i < 10; i++) begin
      drive(1, i == 9, 32'h100 + DW'(i));
      cycle();
    end
    drive(0, 0, '0);
    expect_cc_after(32'h109, 40, "cc_after_straddle");

    // Seventeen writes while output is held off by a correction sequence.
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cycle();
      if (m_ccrem == CC_LEN - 1) hit = 1;
    end
    if (!hit) timeout("overflow_align");
    for (int i = 0; i < 17; i++) begin
      drive(1, i == 15, 32'h200 + DW'(i));
      cycle();
    end
    drive(0, 0, '0);
    cmp("overflow_set", link.OVERFLOW, 1'b1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (link.TX_K === '0 && link.TX_DATA[31:8] === 24'h000002) cnt++;
    end
    cmp("overflow_words_out", cnt, 16);

    rst = 1'b1;
    cycle();
    cmp("rst_clears_overflow", link.OVERFLOW, 1'b0);
    rst = 1'b0;
    repeat (2) cycle();

    // Open frame with a gap: underrun, and the correction waits for EOF.
    drive(1, 0, 32'h300); cycle();
    drive(1, 0, 32'h301); cycle();
    drive(0, 0, '0);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cycle();
      if (m_pend) hit = 1;
    end
    if (!hit) timeout("pending_wait");
    repeat (2) cycle();
    cmp("underrun_set", link.UNDERRUN, 1'b1);
    cmp("no_cc_in_frame", link.TX_DATA, IDLE_D);
    drive(1, 1, 32'h302); cycle();
    drive(0, 0, '0);
    expect_cc_after(32'h302, 10, "cc_after_late_eof");

    // Randomised traffic, light then heavy load.
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      drive($urandom_range(0, 99) < ((i < 600) ? 60 : 95), $urandom_range(0, 7) == 0,
            DW'($urandom()));
      cycle();
    end
    drive(0, 0, '0);
    repeat (40) cycle();

    // Five frames, then reset in the middle of a sixth.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (2) cycle();
    for (int f = 0; f < 5; f++) begin
      for (int w = 0; w < 3; w++) begin
        drive(1, w == 2, DW'($urandom()));
        cycle();
      end
    end
    drive(0, 0, '0);
    repeat (50) cycle();
`ifdef DAQ_LINK_FRAMER_STATS_EN
    cmp("frame_cnt_five", frame_cnt, 32'd5);
`endif
    drive(1, 0, 32'h400); cycle();
    drive(1, 0, 32'h401); cycle();
    drive(0, 0, '0);
    cycle();
    rst = 1'b1;
    cycle();
    cmp("midframe_rst_data", link.TX_DATA, IDLE_D);
    cmp("midframe_rst_k", link.TX_K, IDLE_K);
    cmp("midframe_rst_rdy", link.TXD_RDY, 1'b0);
`ifdef DAQ_LINK_FRAMER_STATS_EN
    cmp("frame_cnt_cleared", frame_cnt, 32'd0);
`endif
    rst = 1'b0;
    repeat (10) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/daq_link_framer.md
# daq_link_framer

Parametrised 8b10b transmit framer for the DAQ optical output path, driving the GTX TXDATA/TXCHARISK inputs. It is the next generation of the DDU output pipeline. It buffers words from the DAQ event builder in a small synchronous FIFO, tracks frame boundaries, fills gaps with idle characters, and inserts clock-correction sequences at a programmable interval without breaking frames. It supports 16- or 32-bit GTX fabric widths.

## Interface
- DW, 16, fabric data width; 16 or 32 only; NK = DW/8 K-flags.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words.
- CC_PERIOD, 5000, clock-correction interval in CLK cycles; must be > CC_LEN + 1.
- CC_LEN, 2, consecutive CC words per insertion; at least 1.
- IDLE_WORD, 16'h50BC, 16-bit idle pattern; replicated DW/16 times.
- IDLE_K, 2'b01, K-flags per 16-bit idle half.
- CC_WORD, 16'hF7F7, 16-bit clock-correction pattern; replicated.
- CC_K, 2'b11, K-flags per 16-bit CC half.

Ports:
- CLK  in  1  word clock (GTX TXUSRCLK2 domain).
- RST  in  1  synchronous, active-high reset.
- TXD  in  DW  data word from event builder.
- TXD_VLD  in  1  TXD valid; a word is written when TXD_VLD && TXD_RDY.
- TXD_EOF  in  1  qualifies TXD as the last word of a frame.
- TXD_RDY  out  1  FIFO not full.
- TX_DATA  out  DW  to GTX TXDATA, registered.
- TX_K  out  NK  to GTX TXCHARISK, registered.
- OVERFLOW  out  1  sticky; set when TXD_VLD is asserted while TXD_RDY=0.
- UNDERRUN  out  1  sticky; set when idle is sent inside a frame.

## Operation
- Reset values: TX_DATA = IDLE, TX_K = IDLE_K replicated, TXD_RDY = 0, OVERFLOW = 0, UNDERRUN = 0, FIFO empty, CC timer = 0, state SEND, in_frame = 0.
- TXD_RDY is registered and rises 1 cycle after RST deasserts.
- Writes while full are dropped and set OVERFLOW. The FIFO contents are not corrupted.
- The CC timer counts every cycle and wraps at CC_PERIOD-1. On wrap it sets cc_pending.
- If a second wrap occurs while cc_pending is still set, cc_pending stays set. The request is not counted twice.
- in_frame is set when a non-EOF data word is sent. It is cleared when an EOF word is sent.
- State SEND, evaluated each cycle:
  - If cc_pending && !in_frame, go to CC, load the CC counter, and clear cc_pending.
  - Else if the FIFO is not empty, pop one word and send it with K = 0.
  - Else send IDLE. If in_frame, also set UNDERRUN.
- State CC: send CC_WORD/CC_K for exactly CC_LEN cycles, then return to SEND. No pops happen during CC.
- A CC is never inserted mid-frame. It waits for the EOF word, then starts on the next cycle.
- Simultaneous push and pop when full: the pop happens, the push is refused, because TXD_RDY was 0 in that cycle.
- Simultaneous push and pop when empty: the pop is not seen. The word appears one cycle later.
- RST mid-frame or mid-CC: return to reset values on the next edge. FIFO contents are discarded.

## Timing
- Write-to-output latency is 2 cycles. A word accepted at edge N is on TX_DATA after edge N+2, provided the FIFO was empty and no CC is active.
- Throughput is 1 word/cycle except during CC cycles.
- TX_DATA/TX_K change only on CLK edges.
- The first CC is requested at timer wrap, CC_PERIOD cycles after reset release. It is sent within 1 cycle if the framer is not in a frame.

## Configuration
- DAQ_LINK_FRAMER_STATS_EN defined adds two ports. Both clear on RST.
  - FRAME_CNT out [31:0]: EOF words sent; wraps.
  - CC_CNT out [15:0]: completed CC insertions; saturates at 16'hFFFF.
- Without DAQ_LINK_FRAMER_STATS_EN, these ports and counters do not exist. All other behaviour is identical.

## Structure
- Package daq_link_pkg holds:
  - state enum {SEND, CC};
  - K-character constants (K28.5 = 8'hBC, K23.7 = 8'hF7);
  - a function that replicates a 16-bit word/K pair to DW.
- Sub-module daq_link_fifo: a synchronous FIFO parametrised by DW+1 (data plus EOF bit) and FIFO_AW.
  - Outputs full and empty flags.
  - Registered read data, with first-word-fall-through off.

## Test plan
- Reset release, no input -> TX_DATA=16'h50BC and TX_K=2'b01 every cycle. TXD_RDY=1 from the 2nd cycle after RST falls.
- Burst of 3 words 16'h0001..16'h0003, EOF on the third -> they appear after edges N+2..N+4 with TX_K=0, followed by idle. UNDERRUN stays 0.
- CC_PERIOD=20, CC_LEN=2, a 10-word frame straddling the wrap -> the CC word pair 16'hF7F7/2'b11 starts the cycle after the EOF word. Frame words are contiguous.
- With DW=32, write 17 words continuously while output is stalled by a CC and FIFO_AW=4 -> 16 words are accepted. The 17th is dropped, OVERFLOW=1, and the stored words emerge intact.
- Frame of 2 words without EOF, then a gap -> idle is sent with UNDERRUN=1. A later EOF clears in_frame and allows the pending CC.
- With DAQ_LINK_FRAMER_STATS_EN, send 5 frames and assert RST mid-frame -> FRAME_CNT=5 before reset and 0 after. TX outputs return to idle on the next edge.
